// File: rtl/wave_gen_pkg.sv
// Shared definitions for the WaveGen phase sources: counting modes and their
// 2-bit encoding.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    MODE_UP      = 2'd0,
    MODE_DOWN    = 2'd1,
    MODE_TRI     = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_t;

  localparam int MODE_W = 2;

endpackage

// File: rtl/wave_counter.sv
// Mod-M phase counter for the waveform generators: up/down sawtooth, triangle
// and one-shot, with a modulus latched only at reload points.
module wave_counter
  import wave_gen_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clear,
  input  mode_t        mode,
  input  logic [N-1:0] M,
  output logic [N-1:0] count,
  output logic         tick,
  output logic         dir,
  output logic         done
);

  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [N-1:0] ZERO = '0;

  logic [N-1:0] r_count;
  logic [N-1:0] r_mcur;
  logic         r_dir;
  logic         r_done;
  logic         r_load_pending;

  logic [N-1:0] w_meff;
  logic [N-1:0] w_meffm;
  logic [N-1:0] w_top;
  logic [N-1:0] w_top_m;
  logic [N-1:0] w_count_next;
  logic [N-1:0] w_mcur_next;
  logic         w_dir_next;
  logic         w_done_next;
  logic         w_tick;
  logic         w_reload;

  // Moduli 0 and 1 both collapse to 1 so count-1 comparisons never underflow.
  always_comb begin
    w_meff  = (r_mcur <= ONE) ? ONE : r_mcur;
    w_meffm = (M <= ONE) ? ONE : M;
    w_top   = w_meff - ONE;
    w_top_m = w_meffm - ONE;
  end

  always_comb begin
    w_count_next = r_count;
    w_dir_next   = r_dir;
    w_done_next  = r_done;
    w_tick       = 1'b0;
    w_reload     = 1'b0;

    if (clear) begin
      w_reload    = 1'b1;
      w_done_next = 1'b0;
      if (mode == MODE_DOWN) begin
        w_count_next = w_top_m;
        w_dir_next   = 1'b0;
      end else begin
        w_count_next = ZERO;
        w_dir_next   = 1'b1;
      end
    end else if (en) begin
      unique case (mode)
        MODE_UP: begin
          w_dir_next  = 1'b1;
          w_done_next = 1'b0;
          if (r_count == w_top) begin
            w_tick       = 1'b1;
            w_reload     = 1'b1;
            w_count_next = ZERO;
          end else begin
            w_count_next = r_count + ONE;
          end
        end

        MODE_DOWN: begin
          w_dir_next  = 1'b0;
          w_done_next = 1'b0;
          if (r_count == ZERO) begin
            w_tick       = 1'b1;
            w_reload     = 1'b1;
            w_count_next = w_top_m;
          end else begin
            w_count_next = r_count - ONE;
          end
        end

        MODE_TRI: begin
          w_done_next = 1'b0;
          if (r_dir) begin
            if (r_count == w_top) begin
              w_tick = 1'b1;
              // A modulus of 1 has no slope to descend; stay rising at 0.
              if (w_meff == ONE) begin
                w_count_next = ZERO;
                w_dir_next   = 1'b1;
              end else begin
                w_count_next = r_count - ONE;
                w_dir_next   = 1'b0;
              end
            end else begin
              w_count_next = r_count + ONE;
            end
          end else begin
            if (r_count == ZERO) begin
              w_tick       = 1'b1;
              w_reload     = 1'b1;
              w_dir_next   = 1'b1;
              w_count_next = (w_meffm == ONE) ? ZERO : ONE;
            end else begin
              w_count_next = r_count - ONE;
            end
          end
        end

        MODE_ONESHOT: begin
          w_dir_next = 1'b1;
          if (!r_done) begin
            if (r_count == w_top) begin
              w_tick      = 1'b1;
              w_done_next = 1'b1;
            end else begin
              w_count_next = r_count + ONE;
            end
          end
        end

        default: begin
          w_count_next = r_count;
        end
      endcase
    end

    // The first clock after reset always picks up the requested modulus.
    w_mcur_next = (w_reload || r_load_pending) ? M : r_mcur;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count        <= ZERO;
      r_mcur         <= ZERO;
      r_dir          <= 1'b1;
      r_done         <= 1'b0;
      r_load_pending <= 1'b1;
    end else begin
      r_count        <= w_count_next;
      r_mcur         <= w_mcur_next;
      r_dir          <= w_dir_next;
      r_done         <= w_done_next;
      r_load_pending <= 1'b0;
    end
  end

  assign count = r_count;
  assign tick  = w_tick;
  assign dir   = r_dir;
  assign done  = r_done;

endmodule

// File: tb/tb_wave_counter.sv
// Directed bench for wave_counter: walks each mode through a hand-written
// sequence of expected count/tick/dir/done values.
module tb_wave_counter;
  import wave_gen_pkg::*;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clear;
  mode_t      mode;
  logic [7:0] M;
  logic [7:0] count;
  logic       tick;
  logic       dir;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  wave_counter #(.N(8)) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clear(clear),
    .mode (mode),
    .M    (M),
    .count(count),
    .tick (tick),
    .dir  (dir),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int up_c[6]    = '{0, 1, 2, 3, 4, 0};
  int dn_c[5]    = '{3, 2, 1, 0, 3};
  int tri_c[8]   = '{0, 1, 2, 3, 2, 1, 0, 1};
  int tri_d[8]   = '{1, 1, 1, 1, 0, 0, 0, 1};
  int tri_t[8]   = '{0, 0, 0, 1, 0, 0, 1, 0};
  int os_c[5]    = '{0, 1, 2, 2, 2};
  int os_t[5]    = '{0, 0, 1, 0, 0};
  int os_d[5]    = '{0, 0, 0, 1, 1};
  int chg_c[12]  = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 0, 0, 0};
  int chg_t[12]  = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1};

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    clear = 1'b0;
    mode  = MODE_UP;
    M     = 8'd5;
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_dir", 32'(dir), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_tick", 32'(tick), 0);
    reset = 1'b0;
    step();
    en = 1'b1;
    #1;

    // UP, M=5
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("up_count[%0d]", i), 32'(count), 32'(up_c[i]));
      chk($sformatf("up_tick[%0d]", i), 32'(tick), (up_c[i] == 4) ? 1 : 0);
      $display("up    i=%0d count=%0d tick=%0d", i, count, tick);
      step();
    end
    chk("up_pre_reset", 32'(count), 1);
    reset = 1'b1;
    #1;
    chk("async_reset_count", 32'(count), 0);

    // DOWN, M=4
    en    = 1'b0;
    mode  = MODE_DOWN;
    M     = 8'd4;
    reset = 1'b0;
    step();
    en = 1'b1;
    #1;
    chk("dn_first_count", 32'(count), 0);
    chk("dn_first_tick", 32'(tick), 1);
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("dn_count[%0d]", i), 32'(count), 32'(dn_c[i]));
      chk($sformatf("dn_tick[%0d]", i), 32'(tick), (dn_c[i] == 0) ? 1 : 0);
      chk($sformatf("dn_dir[%0d]", i), 32'(dir), 0);
      $display("down  i=%0d count=%0d tick=%0d dir=%0d", i, count, tick, dir);
      step();
    end

    // TRI, M=4, started by clear
    mode  = MODE_TRI;
    clear = 1'b1;
    #1;
    chk("tri_clear_tick", 32'(tick), 0);
    step();
    clear = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tri_count[%0d]", i), 32'(count), 32'(tri_c[i]));
      chk($sformatf("tri_tick[%0d]", i), 32'(tick), 32'(tri_t[i]));
      chk($sformatf("tri_dir[%0d]", i), 32'(dir), 32'(tri_d[i]));
      $display("tri   i=%0d count=%0d tick=%0d dir=%0d", i, count, tick, dir);
      step();
    end

    // ONESHOT, M=3
    mode  = MODE_ONESHOT;
    M     = 8'd3;
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("os_count[%0d]", i), 32'(count), 32'(os_c[i]));
      chk($sformatf("os_tick[%0d]", i), 32'(tick), 32'(os_t[i]));
      chk($sformatf("os_done[%0d]", i), 32'(done), 32'(os_d[i]));
      $display("oneshot i=%0d count=%0d tick=%0d done=%0d", i, count, tick, done);
      step();
    end
    clear = 1'b1;
    #1;
    chk("os_clear_tick", 32'(tick), 0);
    step();
    clear = 1'b0;
    #1;
    chk("os_clear_count", 32'(count), 0);
    chk("os_clear_done", 32'(done), 0);

    // ONESHOT with degenerate modulus
    M     = 8'd1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    chk("os1_tick_first", 32'(tick), 1);
    step();
    chk("os1_done", 32'(done), 1);
    chk("os1_tick_after", 32'(tick), 0);
    chk("os1_count", 32'(count), 0);
    $display("oneshot M=1 count=%0d tick=%0d done=%0d", count, tick, done);

    // UP, M=6 -> 3 -> 0
    mode  = MODE_UP;
    M     = 8'd6;
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) M = 8'd3;
      if (i == 7) M = 8'd0;
      #1;
      chk($sformatf("chg_count[%0d]", i), 32'(count), 32'(chg_c[i]));
      chk($sformatf("chg_tick[%0d]", i), 32'(tick), 32'(chg_t[i]));
      $display("mchg  i=%0d M=%0d count=%0d tick=%0d", i, M, count, tick);
      step();
    end

    // clear together with en at the terminal count
    M     = 8'd5;
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (4) step();
    chk("term_count", 32'(count), 4);
    chk("term_tick", 32'(tick), 1);
    clear = 1'b1;
    #1;
    chk("term_clear_tick", 32'(tick), 0);
    step();
    clear = 1'b0;
    #1;
    chk("term_clear_count", 32'(count), 0);
    $display("clear@term count=%0d", count);

    // disabled hold
    repeat (2) step();
    en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_count[%0d]", i), 32'(count), 2);
      chk($sformatf("hold_tick[%0d]", i), 32'(tick), 0);
      chk($sformatf("hold_dir[%0d]", i), 32'(dir), 1);
      chk($sformatf("hold_done[%0d]", i), 32'(done), 0);
      $display("hold  i=%0d count=%0d tick=%0d", i, count, tick);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
